// File: rtl/com_status_sticky_reg_pkg.sv
// Shared constants and types for the pix28 status register instance.
// Index/width helpers used by com_status_sticky_reg and its bit slices.
package cms_pix28_package;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PIX28_NUM_STICKY = 20;
  localparam int PIX28_NUM_LEVEL  = 4;
  localparam int PIX28_DATA_W     = 32;

  localparam int STICKY_LSB = 0;
  localparam int STICKY_MSB = PIX28_NUM_STICKY - 1;
  localparam int LEVEL_LSB  = PIX28_NUM_STICKY;
  localparam int LEVEL_MSB  = PIX28_NUM_STICKY + PIX28_NUM_LEVEL - 1;

  // Bit 3 is a pulse source that must count once per assertion
  localparam logic [PIX28_NUM_STICKY-1:0] PIX28_EDGE_MODE = 20'h0_0008;

  typedef logic [idx_w(PIX28_NUM_STICKY)-1:0] pix28_idx_t;

endpackage

// File: rtl/com_status_sticky_bit.sv
// One sticky status bit: edge/level set detect, set-over-clear priority and
// an optional saturating event counter (COM_STATUS_EVENT_COUNTER_EN).
module com_status_sticky_bit #(
  parameter bit EDGE  = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_evt,
  input  logic             i_clr,
  output logic             o_sticky,
  output logic             o_set
`ifdef COM_STATUS_EVENT_COUNTER_EN
  ,
  output logic [CNT_W-1:0] o_cnt
`endif
);

  logic r_prev;
  logic r_sticky;
  logic w_set;

  assign w_set    = EDGE ? (i_evt & ~r_prev) : i_evt;
  assign o_set    = w_set;
  assign o_sticky = r_sticky;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_prev   <= i_evt;
      r_sticky <= w_set | (r_sticky & ~i_clr);
    end
  end

`ifdef COM_STATUS_EVENT_COUNTER_EN
  logic [CNT_W-1:0] r_cnt;

  assign o_cnt = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= w_set ? CNT_W'(1) : '0;
    end else if (w_set && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/com_status_sticky_reg.sv
// Sticky/level status word with W1C, irq mask, first-event capture.
// Optional per-bit event counters: COM_STATUS_EVENT_COUNTER_EN.
module com_status_sticky_reg
  import cms_pix28_package::*;
#(
  parameter int                    NUM_STICKY = 20,
  parameter int                    NUM_LEVEL  = 4,
  parameter int                    DATA_W     = 32,
  parameter logic [NUM_STICKY-1:0] EDGE_MODE  = '0,
  parameter int                    CNT_W      = 8
) (
  input  logic                          fw_axi_clk,
  input  logic                          fw_rst_n,
  input  logic [NUM_STICKY-1:0]         sticky_evt_i,
  input  logic [NUM_LEVEL-1:0]          level_i,
  input  logic                          clear_all_i,
  input  logic                          w1c_strobe_i,
  input  logic [DATA_W-1:0]             w1c_data_i,
  input  logic                          mask_we_i,
  input  logic [NUM_STICKY-1:0]         mask_data_i,
  input  logic [idx_w(NUM_STICKY)-1:0]  cnt_sel_i,
  output logic [DATA_W-1:0]             fw_read_status_reg,
  output logic [idx_w(NUM_STICKY)-1:0]  first_evt_idx_o,
  output logic                          first_evt_vld_o,
  output logic                          irq_o,
  output logic [CNT_W-1:0]              cnt_rdata_o
);

  localparam int IDX_W = idx_w(NUM_STICKY);

  if (NUM_STICKY + NUM_LEVEL > DATA_W) begin : g_width_chk
    $error("NUM_STICKY+NUM_LEVEL exceeds DATA_W");
  end

  logic [NUM_STICKY-1:0] w_sticky;
  logic [NUM_STICKY-1:0] w_set;
  logic [NUM_STICKY-1:0] w_clr;
  logic [NUM_LEVEL-1:0]  r_level;
  logic [NUM_STICKY-1:0] r_mask;
  logic                  r_irq;
  logic [IDX_W-1:0]      r_first_idx;
  logic                  r_first_vld;
  logic [IDX_W-1:0]      w_low_idx;

`ifdef COM_STATUS_EVENT_COUNTER_EN
  logic [CNT_W-1:0] w_cnt [NUM_STICKY];
  logic [CNT_W-1:0] w_cnt_mux;
  logic [CNT_W-1:0] r_cnt_rd;
  logic             w_unused;

  assign w_unused = ^w1c_data_i;
`else
  logic w_unused;

  assign w_unused = ^{w1c_data_i, cnt_sel_i};
`endif

  for (genvar i = 0; i < NUM_STICKY; i++) begin : g_bit
    assign w_clr[i] = clear_all_i | (w1c_strobe_i & w1c_data_i[i]);

    com_status_sticky_bit #(
      .EDGE  (EDGE_MODE[i]),
      .CNT_W (CNT_W)
    ) u_bit (
      .i_clk    (fw_axi_clk),
      .i_rst_n  (fw_rst_n),
      .i_evt    (sticky_evt_i[i]),
      .i_clr    (w_clr[i]),
      .o_sticky (w_sticky[i]),
      .o_set    (w_set[i])
`ifdef COM_STATUS_EVENT_COUNTER_EN
      ,
      .o_cnt    (w_cnt[i])
`endif
    );
  end

  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_STICKY - 1; i >= 0; i--) begin
      if (w_set[i]) w_low_idx = IDX_W'(i);
    end
  end

  // A clear coinciding with an event re-arms and latches in one step
  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      r_level     <= '0;
      r_mask      <= '0;
      r_irq       <= 1'b0;
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
    end else begin
      r_level <= level_i;
      r_irq   <= |(w_sticky & r_mask);
      if (mask_we_i) r_mask <= mask_data_i;
      if ((!r_first_vld || clear_all_i) && (|w_set)) begin
        r_first_idx <= w_low_idx;
        r_first_vld <= 1'b1;
      end else if (clear_all_i) begin
        r_first_idx <= '0;
        r_first_vld <= 1'b0;
      end
    end
  end

`ifdef COM_STATUS_EVENT_COUNTER_EN
  always_comb begin
    w_cnt_mux = '0;
    for (int i = 0; i < NUM_STICKY; i++) begin
      if (int'(cnt_sel_i) == i) w_cnt_mux = w_cnt[i];
    end
  end

  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) r_cnt_rd <= '0;
    else           r_cnt_rd <= w_cnt_mux;
  end

  assign cnt_rdata_o = r_cnt_rd;
`else
  assign cnt_rdata_o = '0;
`endif

  always_comb begin
    fw_read_status_reg = '0;
    fw_read_status_reg[NUM_STICKY-1:0] = w_sticky;
    fw_read_status_reg[NUM_STICKY +: NUM_LEVEL] = r_level;
  end

  assign first_evt_idx_o = r_first_idx;
  assign first_evt_vld_o = r_first_vld;
  assign irq_o           = r_irq;

endmodule

// File: tb/tb_com_status_sticky_reg.sv
// Directed bench for com_status_sticky_reg (pix28 configuration).
// Counter expectations follow COM_STATUS_EVENT_COUNTER_EN.
module tb_com_status_sticky_reg;
  import cms_pix28_package::*;

`ifdef COM_STATUS_EVENT_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [19:0] evt;
  logic [3:0]  lvl;
  logic        clr_all;
  logic        w1c_stb;
  logic [31:0] w1c_dat;
  logic        mask_we;
  logic [19:0] mask_dat;
  logic [4:0]  cnt_sel;
  logic [31:0] status;
  logic [4:0]  f_idx;
  logic        f_vld;
  logic        irq;
  logic [7:0]  cnt_rd;

  int n_vec;
  int n_err;

  com_status_sticky_reg #(
    .NUM_STICKY (20),
    .NUM_LEVEL  (4),
    .DATA_W     (32),
    .EDGE_MODE  (PIX28_EDGE_MODE),
    .CNT_W      (8)
  ) dut (
    .fw_axi_clk         (clk),
    .fw_rst_n           (rst_n),
    .sticky_evt_i       (evt),
    .level_i            (lvl),
    .clear_all_i        (clr_all),
    .w1c_strobe_i       (w1c_stb),
    .w1c_data_i         (w1c_dat),
    .mask_we_i          (mask_we),
    .mask_data_i        (mask_dat),
    .cnt_sel_i          (cnt_sel),
    .fw_read_status_reg (status),
    .first_evt_idx_o    (f_idx),
    .first_evt_vld_o    (f_vld),
    .irq_o              (irq),
    .cnt_rdata_o        (cnt_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    evt      = 20'h0_0008;
    lvl      = '0;
    clr_all  = 1'b0;
    w1c_stb  = 1'b0;
    w1c_dat  = '0;
    mask_we  = 1'b0;
    mask_dat = '0;
    cnt_sel  = '0;
    #23;
    chk("rst_status", status, 32'h0);
    chk("rst_vld", {31'b0, f_vld}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_cnt", {24'b0, cnt_rd}, 32'h0);

    tick();
    rst_n = 1'b1;
    tick();
    chk("edge_after_rst", status, 32'h8);
    chk("first_idx3", {27'b0, f_idx}, 32'd3);
    chk("first_vld3", {31'b0, f_vld}, 32'h1);
    cnt_sel = 5'd3;
    tick();
    chk("edge_held", status, 32'h8);
    chk("cnt3_one", {24'b0, cnt_rd}, CNT_EN ? 32'd1 : 32'd0);
    tick();
    chk("cnt3_still_one", {24'b0, cnt_rd}, CNT_EN ? 32'd1 : 32'd0);

    evt     = '0;
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    chk("clr_status", status, 32'h0);
    chk("clr_vld", {31'b0, f_vld}, 32'h0);

    evt = 20'h0_0024;
    tick();
    evt = '0;
    chk("pair_status", status, 32'h24);
    chk("pair_idx", {27'b0, f_idx}, 32'd2);
    chk("pair_vld", {31'b0, f_vld}, 32'h1);
    tick();
    chk("pair_sticky", status, 32'h24);

    w1c_stb = 1'b1;
    w1c_dat = 32'h24;
    tick();
    w1c_stb = 1'b0;
    chk("w1c_status", status, 32'h0);
    chk("w1c_keeps_vld", {31'b0, f_vld}, 32'h1);
    chk("w1c_keeps_idx", {27'b0, f_idx}, 32'd2);

    evt = 20'h0_0080;
    tick();
    chk("bit7_set", status, 32'h80);
    w1c_stb = 1'b1;
    w1c_dat = 32'h80;
    tick();
    chk("bit7_set_wins", status, 32'h80);
    evt = '0;
    tick();
    w1c_stb = 1'b0;
    chk("bit7_w1c", status, 32'h0);

    lvl     = 4'b1010;
    w1c_stb = 1'b1;
    w1c_dat = 32'hFFFF_FFFF;
    tick();
    w1c_stb = 1'b0;
    chk("level_bits", status, 32'h00A0_0000);
    lvl = 4'b0101;
    tick();
    chk("level_follow", status, 32'h0050_0000);

    clr_all = 1'b1;
    evt     = 20'h0_0200;
    tick();
    clr_all = 1'b0;
    evt     = '0;
    chk("clr_evt_status", status, 32'h0050_0200);
    chk("clr_evt_idx", {27'b0, f_idx}, 32'd9);
    chk("clr_evt_vld", {31'b0, f_vld}, 32'h1);

    lvl     = '0;
    clr_all = 1'b1;
    tick();
    clr_all  = 1'b0;
    mask_we  = 1'b1;
    mask_dat = 20'h0_0010;
    tick();
    mask_we = 1'b0;
    evt     = 20'h0_0010;
    tick();
    evt = '0;
    chk("irq_n1", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_n2", {31'b0, irq}, 32'h1);
    mask_we  = 1'b1;
    mask_dat = '0;
    tick();
    mask_we = 1'b0;
    chk("irq_mask_n1", {31'b0, irq}, 32'h1);
    tick();
    chk("irq_mask_n2", {31'b0, irq}, 32'h0);

    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    cnt_sel = 5'd0;
    evt     = 20'h0_0001;
    tick(300);
    evt = '0;
    tick(2);
    chk("cnt0_sat", {24'b0, cnt_rd}, CNT_EN ? 32'd255 : 32'd0);
    chk("bit0_status", status, 32'h1);
    cnt_sel = 5'd25;
    tick();
    chk("cnt_oob", {24'b0, cnt_rd}, 32'd0);
    cnt_sel = 5'd0;
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    chk("cnt_clr_vld", {31'b0, f_vld}, 32'h0);
    tick();
    chk("cnt0_clr", {24'b0, cnt_rd}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
